// File: rtl/frame_buffer_writer.sv
// Frame buffer writer: decimates a valid/ready pixel stream 2x in each
// direction and issues registered writes into the half-resolution frame
// buffer. The writer checks line length and frame start on the way, and
// frame capture can be switched on or off at each SOF.
module frame_buffer_writer #(
  parameter int IN_W   = 640,
  parameter int IN_H   = 480,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  input  logic              iSOF,
  input  logic              iEOL,
  output logic              oReady,
  input  logic              iEnable,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddress,
  output logic [DATA_W-1:0] oWrData,
  input  logic              iWrReady,
  output logic              oFrameDone,
  output logic              oLineErr,
  output logic              oFrameErr
);

  localparam int XW = $clog2(IN_W);
  localparam int YW = $clog2(IN_H);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    SKIP     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   lineBase_q, lineBase_d;
  logic                wrEn_q, wrEn_d;
  logic [ADDR_W-1:0]   wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0]   wrData_q, wrData_d;
  logic                frameDone_q, frameDone_d;
  logic                lineErr_q, lineErr_d;
  logic                frameErr_q, frameErr_d;

  // Working copies of the beat's position: a SOF beat is treated as (0,0)
  // of a fresh frame no matter where the counters were.
  state_t              mode;
  logic [XW-1:0]       curX;
  logic [YW-1:0]       curY;
  logic [ADDR_W-1:0]   curBase;
  logic                accept;
  logic                lastPix;
  logic                lineEnd;
  logic                keep;

  // A new beat can enter whenever the output register is free or draining.
  assign oReady = !wrEn_q || iWrReady;

  assign oWrEn      = wrEn_q;
  assign oWrAddress = wrAddr_q;
  assign oWrData    = wrData_q;
  assign oFrameDone = frameDone_q;
  assign oLineErr   = lineErr_q;
  assign oFrameErr  = frameErr_q;

  // Next-state logic: position tracking, decimation, sync checks and write stage.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    lineBase_d  = lineBase_q;
    wrEn_d      = wrEn_q && !iWrReady;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    frameDone_d = 1'b0;
    lineErr_d   = 1'b0;
    frameErr_d  = 1'b0;
    mode        = state_q;
    curX        = x_q;
    curY        = y_q;
    curBase     = lineBase_q;
    accept      = iValid && oReady;
    lastPix     = 1'b0;
    lineEnd     = 1'b0;
    keep        = 1'b0;

    if (accept && (state_q != WAIT_SOF || iSOF)) begin
      if (iSOF) begin
        curX       = '0;
        curY       = '0;
        curBase    = '0;
        mode       = iEnable ? RUN : SKIP;
        frameErr_d = (state_q != WAIT_SOF);
      end

      lastPix   = (curX == XW'(IN_W - 1));
      lineEnd   = iEOL || lastPix;
      lineErr_d = (iEOL != lastPix);
      keep      = (mode == RUN) && !curX[0] && !curY[0];

      if (keep) begin
        wrEn_d   = 1'b1;
        wrAddr_d = curBase + ADDR_W'(curX >> 1);
        wrData_d = iData;
      end

      state_d = mode;
      if (lineEnd) begin
        if (curY == YW'(IN_H - 1)) begin
          frameDone_d = 1'b1;
          state_d     = WAIT_SOF;
          x_d         = '0;
          y_d         = '0;
          lineBase_d  = '0;
        end else begin
          x_d        = '0;
          y_d        = curY + YW'(1);
          lineBase_d = curY[0] ? (curBase + ADDR_W'(IN_W / 2)) : curBase;
        end
      end else begin
        x_d        = curX + XW'(1);
        y_d        = curY;
        lineBase_d = curBase;
      end
    end
  end

  // State and output registers; reset drops any pending write immediately.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q     <= WAIT_SOF;
      x_q         <= '0;
      y_q         <= '0;
      lineBase_q  <= '0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      frameDone_q <= 1'b0;
      lineErr_q   <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      lineBase_q  <= lineBase_d;
      wrEn_q      <= wrEn_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      frameDone_q <= frameDone_d;
      lineErr_q   <= lineErr_d;
      frameErr_q  <= frameErr_d;
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Testbench for frame_buffer_writer on a reduced 16x8 frame. Random data,
// gaps and RAM back-pressure are checked every cycle against a pixel-level
// reference model that works in frame coordinates.
module tb_frame_buffer_writer;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 6;
  localparam int DW = 24;

  logic          iCLK = 1'b0;
  logic          iRST_n = 1'b0;
  logic          iValid = 1'b0;
  logic [DW-1:0] iData = '0;
  logic          iSOF = 1'b0;
  logic          iEOL = 1'b0;
  logic          iEnable = 1'b0;
  logic          iWrReady = 1'b0;
  logic          oReady;
  logic          oWrEn;
  logic [AW-1:0] oWrAddress;
  logic [DW-1:0] oWrData;
  logic          oFrameDone;
  logic          oLineErr;
  logic          oFrameErr;

  frame_buffer_writer #(.IN_W(W), .IN_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .iValid     (iValid),
    .iData      (iData),
    .iSOF       (iSOF),
    .iEOL       (iEOL),
    .oReady     (oReady),
    .iEnable    (iEnable),
    .oWrEn      (oWrEn),
    .oWrAddress (oWrAddress),
    .oWrData    (oWrData),
    .iWrReady   (iWrReady),
    .oFrameDone (oFrameDone),
    .oLineErr   (oLineErr),
    .oFrameErr  (oFrameErr)
  );

  always #5 iCLK = ~iCLK;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state, in frame coordinates.
  bit            active = 0;
  bit            capture = 0;
  int            px = 0;
  int            py = 0;
  bit            expWrEn = 0;
  int            expAddr = 0;
  logic [DW-1:0] expData = '0;
  bit            expDone = 0;
  bit            expLErr = 0;
  bit            expFErr = 0;

  int rdyMode = 0;
  bit rstReq = 0;
  int dutWrites = 0;
  int modelWrites = 0;
  int dutDones = 0;
  int dutLErrs = 0;
  int dutFErrs = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One accepted beat applied to the reference model.
  task automatic modelBeat(input logic [DW-1:0] d, input bit sof, input bit eol,
                           input bit en, output bit kept);
    kept = 0;
    if (!active && !sof) return;
    if (sof) begin
      if (active) expFErr = 1;
      px = 0;
      py = 0;
      active = 1;
      capture = en;
    end
    if (capture && (px % 2 == 0) && (py % 2 == 0)) begin
      kept = 1;
      expAddr = (py / 2) * (W / 2) + px / 2;
      expData = d;
    end
    if (eol || px == W - 1) begin
      if (eol != (px == W - 1)) expLErr = 1;
      if (py == H - 1) begin
        expDone = 1;
        active = 0;
        px = 0;
        py = 0;
      end else begin
        px = 0;
        py++;
      end
    end else begin
      px++;
    end
  endtask

  // One clock: check registered outputs, drive inputs, update the model.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit sof,
                       input bit eol, input bit en, output bit acc);
    bit kept;
    logic [31:0] r;
    @(negedge iCLK);
    checkOutput("wrEn", oWrEn, expWrEn);
    if (expWrEn) begin
      checkOutput("wrAddr", oWrAddress, expAddr);
      checkOutput("wrData", oWrData, expData);
    end
    checkOutput("frameDone", oFrameDone, expDone);
    checkOutput("lineErr", oLineErr, expLErr);
    checkOutput("frameErr", oFrameErr, expFErr);
    if (oFrameDone === 1'b1) dutDones++;
    if (oLineErr === 1'b1) dutLErrs++;
    if (oFrameErr === 1'b1) dutFErrs++;

    iValid  = v;
    iData   = d;
    iSOF    = sof;
    iEOL    = eol;
    iEnable = en;
    iRST_n  = !rstReq;
    r = $urandom;
    case (rdyMode)
      0:       iWrReady = 1'b1;
      1:       iWrReady = (r % 3 == 0);
      2:       iWrReady = r[0];
      default: iWrReady = 1'b0;
    endcase
    #1;
    checkOutput("ready", oReady, !expWrEn || iWrReady);
    acc = !rstReq && v && (!expWrEn || iWrReady);
    if (!rstReq && oWrEn && iWrReady) dutWrites++;
    if (!rstReq && expWrEn && iWrReady) modelWrites++;

    expDone = 0;
    expLErr = 0;
    expFErr = 0;
    if (rstReq) begin
      expWrEn = 0;
      active = 0;
      capture = 0;
      px = 0;
      py = 0;
    end else begin
      kept = 0;
      if (acc) modelBeat(d, sof, eol, en, kept);
      if (kept) expWrEn = 1;
      else if (iWrReady) expWrEn = 0;
    end
  endtask

  // Present one beat and hold it until accepted, with a cycle budget.
  task automatic applyStimulus(input logic [DW-1:0] d, input bit sof, input bit eol, input bit en);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      cycle(1'b1, d, sof, eol, en, acc);
      n++;
    end
    if (!acc) checkOutput("acceptTimeout", 0, 1);
  endtask

  task automatic idle();
    bit acc;
    logic [31:0] r;
    r = $urandom;
    cycle(1'b0, r[DW-1:0], 1'b0, 1'b0, r[31], acc);
  endtask

  task automatic drain(input int n);
    rdyMode = 0;
    repeat (n) idle();
  endtask

  // Non-SOF beats while waiting for a frame start.
  task automatic sendGarbage(input int n);
    logic [31:0] r;
    repeat (n) begin
      r = $urandom;
      applyStimulus(r[DW-1:0], 1'b0, r[30], r[31]);
    end
  endtask

  // Stream one frame; optional short line, missing EOL, injected SOF, early stop.
  task automatic sendFrame(input bit en, input int shortY, input int shortX, input int dropY,
                           input int sofY, input int sofX, input int stopY, input int stopX);
    int gx;
    int gy;
    bit sof;
    bit eol;
    bit inj;
    logic [31:0] r;
    gx = 0;
    gy = 0;
    inj = 0;
    while (gy < H) begin
      sof = (gx == 0 && gy == 0);
      if (!inj && gy == sofY && gx == sofX) begin
        sof = 1;
        inj = 1;
        gx = 0;
        gy = 0;
      end
      eol = (gy == shortY) ? (gx == shortX) : (gx == W - 1);
      if (gy == dropY && gx == W - 1) eol = 0;
      r = $urandom;
      applyStimulus(r[DW-1:0], sof, eol, sof ? en : r[31]);
      if (gy == stopY && gx == stopX) return;
      if (eol || gx == W - 1) begin
        gx = 0;
        gy++;
      end else begin
        gx++;
      end
      if ($urandom % 4 == 0) idle();
    end
  endtask

  // Runs one frame scenario and checks write/pulse totals against fixed counts.
  task automatic runCase(input string name, input int mode, input bit en, input int shortY,
                         input int shortX, input int dropY, input int sofY, input int sofX,
                         input int wantWrites, input int wantDones, input int wantLErr,
                         input int wantFErr);
    int w0, d0, l0, f0;
    w0 = dutWrites;
    d0 = dutDones;
    l0 = dutLErrs;
    f0 = dutFErrs;
    rdyMode = mode;
    sendGarbage(3);
    sendFrame(en, shortY, shortX, dropY, sofY, sofX, -1, -1);
    drain(4);
    checkOutput({name, "Writes"}, dutWrites - w0, wantWrites);
    checkOutput({name, "Dones"}, dutDones - d0, wantDones);
    checkOutput({name, "LineErrs"}, dutLErrs - l0, wantLErr);
    checkOutput({name, "FrameErrs"}, dutFErrs - f0, wantFErr);
    checkOutput({name, "ModelWrites"}, dutWrites, modelWrites);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0;
    iRST_n = 1'b0;
    repeat (3) @(posedge iCLK);

    runCase("full",     0, 1'b1, -1, -1, -1, -1, -1, 32, 1, 0, 0);
    runCase("stall",    1, 1'b1, -1, -1, -1, -1, -1, 32, 1, 0, 0);
    runCase("shortEol", 2, 1'b1,  2,  5, -1, -1, -1, 27, 1, 1, 0);
    runCase("sofInj",   1, 1'b1, -1, -1, -1,  7, 10, 64, 1, 0, 1);
    runCase("disabled", 2, 1'b0, -1, -1, -1, -1, -1,  0, 1, 0, 0);
    runCase("reenable", 1, 1'b1, -1, -1, -1, -1, -1, 32, 1, 0, 0);
    runCase("dropEol",  0, 1'b1, -1, -1,  3, -1, -1, 32, 1, 1, 0);

    // Reset while a write is stalled at a kept pixel mid-frame.
    rdyMode = 0;
    sendFrame(1'b1, -1, -1, -1, -1, -1, 4, 8);
    rdyMode = 3;
    repeat (3) idle();
    w0 = dutWrites;
    rstReq = 1;
    idle();
    rstReq = 0;
    idle();
    checkOutput("rstNoWrite", dutWrites - w0, 0);
    rdyMode = 0;
    runCase("afterRst", 2, 1'b1, -1, -1, -1, -1, -1, 32, 1, 0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Writer side of the 320x240 24-bit frame buffer that the VGA display path reads and upscales 2x.
- Accepts a 640x480 pixel stream (camera or image pipeline) over a valid/ready handshake.
- Decimates the stream 2x in each direction, keeping the top-left pixel of every 2x2 block.
- Issues registered write address/data/enable to the buffer RAM port, with frame/line sync checking and per-frame enable.

Parameters:
- IN_W, 640, input pixels per line (even).
- IN_H, 480, input lines per frame (even).
- ADDR_W, 17, buffer address width; must hold (IN_W/2)*(IN_H/2)-1.
- DATA_W, 24, pixel width, {B[23:16],G[15:8],R[7:0]}.

Ports:
- iCLK  in  1  pixel-stream/RAM clock.
- iRST_n  in  1  synchronous active-low reset.
- iValid  in  1  input beat valid.
- iData  in  DATA_W  input pixel.
- iSOF  in  1  beat is pixel (0,0) of a frame.
- iEOL  in  1  beat is last pixel of a line.
- oReady  out  1  beat accepted when iValid && oReady.
- iEnable  in  1  frame capture enable, sampled on the SOF beat.
- oWrEn  out  1  RAM write enable.
- oWrAddress  out  ADDR_W  RAM write address.
- oWrData  out  DATA_W  RAM write data.
- iWrReady  in  1  RAM port accepts the write this cycle.
- oFrameDone  out  1  1-cycle pulse when a frame completes.
- oLineErr  out  1  1-cycle pulse on a line-length mismatch.
- oFrameErr  out  1  1-cycle pulse on an unexpected SOF.

Behaviour:
- Reset (iRST_n low at a clock edge):
  - All outputs 0. Counters x=0, y=0, line_base=0. State WAIT_SOF.
  - A pending write is dropped. Reset applies mid-frame or mid-stall without exception.
- Handshake:
  - oReady = !oWrEn || iWrReady (combinational).
  - A beat is accepted iff iValid && oReady.
- Output stage:
  - A kept beat accepted at edge N drives oWrEn=1 with address/data from edge N.
  - oWrEn, oWrAddress and oWrData hold stable while oWrEn && !iWrReady.
  - oWrEn clears on the next edge after iWrReady, unless a new kept beat is accepted that cycle.
- States:
  - WAIT_SOF: beats without iSOF are accepted and discarded. A beat with iSOF moves to RUN if iEnable=1, otherwise to SKIP; that beat is pixel (0,0).
  - RUN: track x (0..IN_W-1) and y (0..IN_H-1). The beat is kept iff x[0]==0 && y[0]==0.
  - Kept-beat address = line_base + x>>1. Maximum address = 76799 at defaults.
  - SKIP: counters run identically to RUN, but nothing is written. oFrameDone and the error pulses still fire.
- End of line: a beat ends the line when iEOL=1 or x==IN_W-1.
  - On a line end: x <= 0, y <= y+1.
  - If the line just ended has y odd, line_base <= line_base + IN_W/2.
  - oLineErr pulses when iEOL=1 with x != IN_W-1, or when x==IN_W-1 with iEOL=0.
- End of frame: a line end with y==IN_H-1:
  - oFrameDone pulses on the next cycle, in both RUN and SKIP.
  - State moves to WAIT_SOF; counters and line_base clear.
- Unexpected SOF: iSOF on an accepted beat in RUN/SKIP that is not the frame's first beat.
  - oFrameErr pulses; no oFrameDone.
  - Counters restart with this beat as (0,0); iEnable is re-sampled to choose RUN/SKIP.
- Priority when events coincide on one beat: SOF restart > frame end > line end.
  - SOF on the beat after a frame end (state WAIT_SOF) is normal and raises no error.
- Widths:
  - x is ceil(log2 IN_W) bits, y is ceil(log2 IN_H) bits, line_base is ADDR_W bits.
  - No wrap beyond IN_W-1 or IN_H-1, because forced line/frame ends prevent it.

Test Plan:
- Full frame, iEnable=1, iData = y*640+x, iWrReady=1 → exactly 76800 writes at addresses 0..76799; address k holds (2*(k/320))*640 + 2*(k%320); one oFrameDone; no error pulses.
- Same frame with iWrReady toggling 1-of-3 cycles → oReady low whenever oWrEn && !iWrReady; oWrAddress/oWrData stable while stalled; write set identical to the first test.
- Line 2 with iEOL at x=99 → oLineErr pulses once; line 3 still starts at x=0; line 2's writes cover only addresses 320..369; line 4 writes start at address 640.
- SOF injected at (x=10, y=7) → oFrameErr pulses; the next kept beat writes address 0; the full frame then completes with oFrameDone.
- iEnable=0 at SOF → zero writes for the whole frame; oFrameDone still pulses; the next frame with iEnable=1 writes normally.
- Reset asserted during a stalled write at (x=200, y=100) → next cycle oWrEn=0 and oReady=1; non-SOF beats are discarded until a SOF arrives.
